// File: rtl/meas_sched.sv
// Measurement scheduler: arbitrates key, host and periodic auto requests, fires the
// measurement engine one request at a time, supervises completion with a timeout and
// keeps the engine quiet for a fixed gap after every measurement.
module meas_sched #(
    parameter int unsigned DW             = 16,
    parameter int unsigned TIMEOUT_US     = 38000,
    parameter int unsigned GAP_US         = 10000,
    parameter int unsigned AUTO_PERIOD_US = 100000
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          pluse_us,
    input  logic          key_req,
    input  logic          host_req,
    input  logic          auto_en,
    output logic          fire_measure,
    input  logic          done_measure,
    input  logic          err_measure,
    input  logic [DW-1:0] data_measure,
    output logic          busy,
    output logic [DW-1:0] result,
    output logic          result_vld,
    output logic [1:0]    result_src,
    output logic [1:0]    status,
    output logic [7:0]    meas_cnt
);

    // One shared µs counter serves both the WAIT timeout and the GAP quiet time.
    localparam int unsigned TmrMax = (TIMEOUT_US > GAP_US) ? TIMEOUT_US : GAP_US;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam int unsigned AutoW  = $clog2(AUTO_PERIOD_US + 1);

    localparam logic [TmrW-1:0]  TimeoutVal = TmrW'(TIMEOUT_US);
    localparam logic [TmrW-1:0]  GapVal     = TmrW'(GAP_US);
    localparam logic [AutoW-1:0] AutoVal    = AutoW'(AUTO_PERIOD_US);

    localparam logic [1:0] SrcKey  = 2'd1;
    localparam logic [1:0] SrcHost = 2'd2;
    localparam logic [1:0] SrcAuto = 2'd3;

    localparam logic [1:0] StatOk      = 2'd0;
    localparam logic [1:0] StatErr     = 2'd1;
    localparam logic [1:0] StatTimeout = 2'd2;

    typedef enum logic [1:0] {StIdle, StFire, StWait, StGap} state_e;

    state_e          state_q, state_d;
    logic            pend_host_q, pend_host_d;
    logic            pend_key_q, pend_key_d;
    logic            pend_auto_q, pend_auto_d;
    logic [1:0]      grant_q, grant_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic [AutoW-1:0] auto_tmr_q, auto_tmr_d;
    logic [DW-1:0]   result_q, result_d;
    logic [1:0]      status_q, status_d;
    logic [1:0]      src_q, src_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            vld_q, vld_d;
    logic            fire_q;
    logic            busy_q;

    logic            grant_host, grant_key, grant_auto;
    logic            wait_exit;
    logic [TmrW-1:0] tmr_inc;
    logic [AutoW-1:0] auto_inc;

    assign tmr_inc  = tmr_q + TmrW'(1);
    assign auto_inc = auto_tmr_q + AutoW'(1);

    // FSM next state, grant selection, completion bookkeeping and µs counter.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        tmr_d      = tmr_q;
        result_d   = result_q;
        status_d   = status_q;
        src_d      = src_q;
        cnt_d      = cnt_q;
        vld_d      = 1'b0;
        grant_host = 1'b0;
        grant_key  = 1'b0;
        grant_auto = 1'b0;
        wait_exit  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pend_host_q) begin
                    grant_host = 1'b1;
                    grant_d    = SrcHost;
                    state_d    = StFire;
                end else if (pend_key_q) begin
                    grant_key = 1'b1;
                    grant_d   = SrcKey;
                    state_d   = StFire;
                end else if (pend_auto_q) begin
                    grant_auto = 1'b1;
                    grant_d    = SrcAuto;
                    state_d    = StFire;
                end
            end
            StFire: begin
                tmr_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (pluse_us) begin
                    tmr_d = tmr_inc;
                end
                // Error beats done, and any engine response beats the timeout.
                if (err_measure) begin
                    status_d  = StatErr;
                    wait_exit = 1'b1;
                end else if (done_measure) begin
                    status_d  = StatOk;
                    result_d  = data_measure;
                    wait_exit = 1'b1;
                end else if (pluse_us && (tmr_inc == TimeoutVal)) begin
                    status_d  = StatTimeout;
                    wait_exit = 1'b1;
                end
                if (wait_exit) begin
                    state_d = StGap;
                    tmr_d   = '0;
                    vld_d   = 1'b1;
                    src_d   = grant_q;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            StGap: begin
                if (pluse_us) begin
                    if (tmr_inc == GapVal) begin
                        state_d = StIdle;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_inc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pending request flags and the auto-request period timer.
    always_comb begin
        // A request arriving while its flag is set (even in the grant cycle) is merged.
        pend_host_d = grant_host ? 1'b0 : (pend_host_q | host_req);
        pend_key_d  = grant_key ? 1'b0 : (pend_key_q | key_req);
        pend_auto_d = pend_auto_q;
        auto_tmr_d  = auto_tmr_q;

        if (!auto_en) begin
            auto_tmr_d  = '0;
            pend_auto_d = 1'b0;
        end else begin
            pend_auto_d = grant_auto ? 1'b0 : pend_auto_q;
            if (pluse_us) begin
                if (auto_inc == AutoVal) begin
                    auto_tmr_d  = '0;
                    pend_auto_d = 1'b1;
                end else begin
                    auto_tmr_d = auto_inc;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q     <= StIdle;
            pend_host_q <= 1'b0;
            pend_key_q  <= 1'b0;
            pend_auto_q <= 1'b0;
            grant_q     <= 2'd0;
            tmr_q       <= '0;
            auto_tmr_q  <= '0;
            result_q    <= '0;
            status_q    <= 2'd0;
            src_q       <= 2'd0;
            cnt_q       <= 8'd0;
            vld_q       <= 1'b0;
            fire_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_host_q <= pend_host_d;
            pend_key_q  <= pend_key_d;
            pend_auto_q <= pend_auto_d;
            grant_q     <= grant_d;
            tmr_q       <= tmr_d;
            auto_tmr_q  <= auto_tmr_d;
            result_q    <= result_d;
            status_q    <= status_d;
            src_q       <= src_d;
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
            fire_q      <= (state_d == StFire);
            busy_q      <= (state_d != StIdle);
        end
    end

    assign fire_measure = fire_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_vld   = vld_q;
    assign result_src   = src_q;
    assign status       = status_q;
    assign meas_cnt     = cnt_q;

endmodule
